// File: rtl/seq_alu.sv
// Registered WIDTH-bit ALU with valid/ready handshake on both sides and a persistent ZCVN flag register.
// Define SEQ_ALU_MUL_EN to build the iterative shift-and-add multiplier for opcode 1110.
module seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             negative,
    output logic             illegal
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_NOT  = 4'b0101;
    localparam logic [3:0] OP_LAND = 4'b0110;
    localparam logic [3:0] OP_LOR  = 4'b0111;
    localparam logic [3:0] OP_LXOR = 4'b1000;
    localparam logic [3:0] OP_LNOT = 4'b1001;
    localparam logic [3:0] OP_ADC  = 4'b1010;
    localparam logic [3:0] OP_SBC  = 4'b1011;
    localparam logic [3:0] OP_SHL  = 4'b1100;
    localparam logic [3:0] OP_SHR  = 4'b1101;
    localparam logic [3:0] OP_MUL  = 4'b1110;
    localparam logic [3:0] OP_CMP  = 4'b1111;

    function automatic logic add_ovf(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                     input logic [WIDTH-1:0] r);
        return (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
    endfunction

    function automatic logic sub_ovf(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                     input logic [WIDTH-1:0] r);
        return (x[WIDTH-1] != y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
    endfunction

    function automatic logic [WIDTH-1:0] bool_res(input logic bit_v);
        return {{(WIDTH-1){1'b0}}, bit_v};
    endfunction

    logic             accept;
    logic             load_single;
    logic             cin;
    logic             bin;
    logic [WIDTH:0]   sum_w;
    logic [WIDTH:0]   diff_w;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] zn_src;
    logic             alu_c;
    logic             alu_v;
    logic             alu_z;
    logic             alu_n;
    logic             alu_ill;
    logic             a_nz;
    logic             b_nz;

    assign accept = in_valid && in_ready;

    // Stored carry doubles as carry-in for ADC and borrow-in for SBC.
    assign cin    = (opcode == OP_ADC) ? carry : 1'b0;
    assign bin    = (opcode == OP_SBC) ? carry : 1'b0;
    assign sum_w  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    assign diff_w = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bin};
    assign a_nz   = (a != '0);
    assign b_nz   = (b != '0);

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_ill = 1'b0;
        case (opcode)
            OP_ADD, OP_ADC: begin
                alu_res = sum_w[WIDTH-1:0];
                alu_c   = sum_w[WIDTH];
                alu_v   = add_ovf(a, b, sum_w[WIDTH-1:0]);
            end
            OP_SUB, OP_SBC: begin
                alu_res = diff_w[WIDTH-1:0];
                alu_c   = diff_w[WIDTH];
                alu_v   = sub_ovf(a, b, diff_w[WIDTH-1:0]);
            end
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_NOT:  alu_res = ~a;
            OP_LAND: alu_res = bool_res(a_nz && b_nz);
            OP_LOR:  alu_res = bool_res(a_nz || b_nz);
            OP_LXOR: alu_res = bool_res(a_nz ^ b_nz);
            OP_LNOT: alu_res = bool_res(!a_nz);
            OP_SHL: begin
                alu_res = {a[WIDTH-2:0], 1'b0};
                alu_c   = a[WIDTH-1];
            end
            OP_SHR: begin
                alu_res = {1'b0, a[WIDTH-1:1]};
                alu_c   = a[0];
            end
            OP_CMP: begin
                alu_res = a;
                alu_c   = diff_w[WIDTH];
                alu_v   = sub_ovf(a, b, diff_w[WIDTH-1:0]);
            end
            default: begin
                alu_res = '0;
                alu_ill = 1'b1;
            end
        endcase
    end

    // CMP reports Z/N of the difference while passing a through as the result.
    assign zn_src = (opcode == OP_CMP) ? diff_w[WIDTH-1:0] : alu_res;
    assign alu_z  = (zn_src == '0);
    assign alu_n  = zn_src[WIDTH-1];

`ifdef SEQ_ALU_MUL_EN
    typedef enum logic {
        S_IDLE,
        S_MUL
    } state_t;

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] acc_next;
    logic               mul_done;
    logic               mul_busy;
    logic               mul_ovf;
    logic               is_mul;

    assign is_mul      = (opcode == OP_MUL);
    assign load_single = accept && !is_mul;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept && is_mul) state_d = S_MUL;
            S_MUL:   if (cnt_q == CNT_LAST) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mul_busy = (state_q == S_MUL);
        mul_done = mul_busy && (cnt_q == CNT_LAST);
        in_ready = !mul_busy && (!out_valid || out_ready);
    end

    // One partial product per cycle; the final add is written straight into the result.
    assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign mul_ovf  = (acc_next[2*WIDTH-1:WIDTH] != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= '0;
        end else if (mul_busy) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (accept && is_mul) begin
            acc_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, a};
            mplier_q <= b;
        end else if (mul_busy) begin
            acc_q    <= acc_next;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
        end
    end
`else
    assign load_single = accept;
    assign in_ready    = !out_valid || out_ready;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            negative  <= 1'b0;
            illegal   <= 1'b0;
        end else if (load_single) begin
            out_valid <= 1'b1;
            result    <= alu_res;
            illegal   <= alu_ill;
            if (!alu_ill) begin
                zero     <= alu_z;
                carry    <= alu_c;
                overflow <= alu_v;
                negative <= alu_n;
            end
`ifdef SEQ_ALU_MUL_EN
        end else if (mul_done) begin
            out_valid <= 1'b1;
            result    <= acc_next[WIDTH-1:0];
            illegal   <= 1'b0;
            zero      <= (acc_next[WIDTH-1:0] == '0);
            carry     <= mul_ovf;
            overflow  <= mul_ovf;
            negative  <= acc_next[WIDTH-1];
`endif
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
